axi_stream_write_feeder: RTL and testbench

- Sits directly upstream of the aligned AXI4 write master.
- Accepts a job (base address, total byte count) and a valid/ready data stream, and buffers the data in an internal FIFO.
- Issues chunked write requests (addr, len, req) to the write master, and forwards buffered beats on its data port.
- Each request is issued only once the FIFO holds the whole chunk, so the master never starves mid-burst.

---
 rtl/axi_stream_write_feeder_pkg.sv | 14 +
 rtl/axi_stream_write_feeder_stream_sync_fifo.sv | 51 +++++
 rtl/axi_stream_write_feeder.sv | 130 +++++++++++++
 tb/tb_axi_stream_write_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_write_feeder_pkg.sv
// Shared types for the stream write feeder: FSM state encoding and beat-size default.
package axi_stream_write_feeder_pkg;

  localparam int D_POWER_DEFAULT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_RUN,
    S_FINISH
  } state_t;

endpackage

// File: rtl/axi_stream_write_feeder_stream_sync_fifo.sv
// First-word-fall-through sync FIFO; head visible the cycle after push, 0-cycle pop.
// Pushes while full and pops while empty are dropped; depth must be a power of two.
module stream_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             sys_clock,
  input  logic             async_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge sys_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge sys_clock or posedge async_reset) begin
    if (async_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_stream_write_feeder.sv
// Buffers a job's stream and issues write requests only once a whole chunk is buffered.
// Data passes FIFO with 1-cycle latency; s_ready drops when FIFO full or job fully accepted.
module axi_stream_write_feeder
  import axi_stream_write_feeder_pkg::*;
#(
  parameter int D_POWER     = D_POWER_DEFAULT,
  parameter int D_WIDTH     = 8 * (1 << D_POWER),
  parameter int FIFO_AW     = 9,
  parameter int CHUNK_BEATS = 256
) (
  input  logic               sys_clock,
  input  logic               async_reset,
  input  logic               i_start,
  input  logic [31:0]        i_base_addr,
  input  logic [31:0]        i_total_len,
  output logic               o_done,
  output logic               o_busy,
  input  logic [D_WIDTH-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [31:0]        o_req_addr,
  output logic [31:0]        o_req_len,
  output logic               o_req,
  input  logic               i_wr_busy,
  output logic [D_WIDTH-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready
);

  localparam int BW = 32 - D_POWER;
  localparam logic [BW-1:0] CHUNK_MAX = BW'(CHUNK_BEATS);

  state_t            state;
  logic [31:0]       addr;
  logic [BW-1:0]     rem_in;
  logic [BW-1:0]     rem_req;
  logic [BW-1:0]     chunk;
  logic [BW-1:0]     fifo_count_ext;
  logic [31:0]       chunk_bytes;
  logic [BW-1:0]     start_beats;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              unused_len_lsbs;

  // Byte count is beat-aligned by contract, so its low bits carry no information.
  assign unused_len_lsbs = ^i_total_len[D_POWER-1:0];
  assign start_beats     = i_total_len[31:D_POWER];

  assign chunk          = (rem_req < CHUNK_MAX) ? rem_req : CHUNK_MAX;
  assign chunk_bytes    = {chunk, {D_POWER{1'b0}}};
  assign fifo_count_ext = BW'(fifo_count);

  assign s_ready = o_busy & (rem_in != '0) & ~fifo_full;
  assign push    = s_valid & s_ready;
  assign o_valid = ~fifo_empty;
  assign pop     = o_valid & i_ready;

  stream_sync_fifo #(
    .WIDTH (D_WIDTH),
    .DEPTH (1 << FIFO_AW)
  ) u_fifo (
    .sys_clock   (sys_clock),
    .async_reset (async_reset),
    .push        (push),
    .push_data   (s_data),
    .pop         (pop),
    .pop_data    (o_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
  );

  always_ff @(posedge sys_clock or posedge async_reset) begin
    if (async_reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      rem_in     <= '0;
      rem_req    <= '0;
      o_req      <= 1'b0;
      o_req_addr <= '0;
      o_req_len  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (push) rem_in <= rem_in - BW'(1);
      case (state)
        S_IDLE: begin
          if (i_start) begin
            addr    <= i_base_addr;
            rem_in  <= start_beats;
            rem_req <= start_beats;
            o_busy  <= 1'b1;
            state   <= (start_beats == '0) ? S_FINISH : S_WAIT;
          end
        end
        // The master comes out of reset busy; never request until it has been seen idle.
        S_WAIT: begin
          if (!i_wr_busy && fifo_count_ext >= chunk) begin
            o_req_addr <= addr;
            o_req_len  <= chunk_bytes;
            o_req      <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_wr_busy) begin
            o_req   <= 1'b0;
            addr    <= addr + chunk_bytes;
            rem_req <= rem_req - chunk;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (!i_wr_busy) state <= (rem_req != '0) ? S_WAIT : S_FINISH;
        end
        S_FINISH: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_write_feeder.sv
// Bench for axi_stream_write_feeder: random data/gaps, behavioural write-master model,
// expected requests and beat order derived from job parameters alone.
module tb_axi_stream_write_feeder;

  localparam int DP    = 3;
  localparam int DW    = 64;
  localparam int CHUNK = 256;

  logic          sys_clock = 1'b0;
  logic          async_reset;
  logic          i_start;
  logic [31:0]   i_base_addr;
  logic [31:0]   i_total_len;
  logic          o_done;
  logic          o_busy;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   o_req_addr;
  logic [31:0]   o_req_len;
  logic          o_req;
  logic          i_wr_busy;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;

  axi_stream_write_feeder dut (
    .sys_clock   (sys_clock),
    .async_reset (async_reset),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_total_len (i_total_len),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .o_req_addr  (o_req_addr),
    .o_req_len   (o_req_len),
    .o_req       (o_req),
    .i_wr_busy   (i_wr_busy),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  always #5 sys_clock = ~sys_clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_dat_q[$];
  logic [DW-1:0] got_q[$];
  logic [31:0]   exp_addr_q[$];
  logic [31:0]   exp_len_q[$];
  logic [31:0]   req_addr_q[$];
  logic [31:0]   req_len_q[$];

  int            src_acc;
  int            done_cnt;
  int            req_while_busy;
  int            src_gap;
  int            rdy_gap;
  int            mst_rem;
  bit            rdy_allow;
  bit            force_busy;
  bit            mst_act;
  bit            mst_hold;
  bit            src_fire;
  bit            snk_fire;
  logic [DW-1:0] snk_dat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: account for the handshakes of the edge just passed, then drive the next cycle.
  task automatic tick();
    @(negedge sys_clock);
    if (src_fire) begin
      void'(src_q.pop_front());
      src_acc++;
    end
    if (snk_fire) begin
      got_q.push_back(snk_dat);
      mst_rem--;
    end
    if (o_done) done_cnt++;
    if (o_req && i_wr_busy) req_while_busy++;

    if (mst_act && mst_rem == 0 && !mst_hold) begin
      mst_act = 1'b0;
    end else if (!mst_act && o_req) begin
      req_addr_q.push_back(o_req_addr);
      req_len_q.push_back(o_req_len);
      mst_act = 1'b1;
      mst_rem = int'(o_req_len >> DP);
    end
    i_wr_busy = mst_act || force_busy;

    if (src_q.size() > 0 && ((s_valid && !src_fire) || $urandom_range(0, 99) >= src_gap)) begin
      s_valid = 1'b1;
      s_data  = src_q[0];
    end else begin
      s_valid = 1'b0;
    end
    i_ready = mst_act && mst_rem > 0 && rdy_allow && ($urandom_range(0, 99) >= rdy_gap);

    #1;
    src_fire = s_valid && s_ready;
    snk_fire = o_valid && i_ready;
    snk_dat  = o_data;
  endtask

  task automatic start_job(input logic [31:0] base, input logic [31:0] len);
    int          beats;
    int          r;
    int          c;
    logic [31:0] a;
    logic [DW-1:0] d;
    got_q.delete();
    exp_dat_q.delete();
    exp_addr_q.delete();
    exp_len_q.delete();
    req_addr_q.delete();
    req_len_q.delete();
    src_acc        = 0;
    done_cnt       = 0;
    req_while_busy = 0;
    beats = int'(len >> DP);
    for (int i = 0; i < beats; i++) begin
      d = {$urandom, $urandom};
      src_q.push_back(d);
      exp_dat_q.push_back(d);
    end
    a = base;
    r = beats;
    while (r > 0) begin
      c = (r < CHUNK) ? r : CHUNK;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(32'(c) << DP);
      a = a + (32'(c) << DP);
      r = r - c;
    end
    i_base_addr = base;
    i_total_len = len;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 20000) begin
      tick();
      n++;
    end
    check({tag, " timeout"}, 64'(n < 20000), 64'd1);
    tick();
    tick();
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_after"}, 64'(o_busy), 64'd0);
    check({tag, " req_count"}, 64'(req_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < req_addr_q.size() && i < exp_addr_q.size(); i++) begin
      check($sformatf("%s req%0d_addr", tag, i), 64'(req_addr_q[i]), 64'(exp_addr_q[i]));
      check($sformatf("%s req%0d_len", tag, i), 64'(req_len_q[i]), 64'(exp_len_q[i]));
    end
    check({tag, " beat_count"}, 64'(got_q.size()), 64'(exp_dat_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_dat_q.size(); i++) begin
      check($sformatf("%s beat%0d", tag, i), got_q[i], exp_dat_q[i]);
    end
    check({tag, " req_while_busy"}, 64'(req_while_busy), 64'd0);
  endtask

  initial begin
    logic [31:0] rbase;
    logic [31:0] rlen;
    int n;

    async_reset = 1'b1;
    i_start = 1'b0; i_base_addr = '0; i_total_len = '0;
    s_valid = 1'b0; s_data = '0; i_ready = 1'b0; i_wr_busy = 1'b1;
    src_gap = 0; rdy_gap = 0; rdy_allow = 1'b1; force_busy = 1'b1;
    mst_act = 1'b0; mst_hold = 1'b0; mst_rem = 0; src_fire = 1'b0; snk_fire = 1'b0;
    snk_dat = '0; src_acc = 0; done_cnt = 0; req_while_busy = 0;

    tick();
    tick();
    check("rst o_req", 64'(o_req), 64'd0);
    check("rst o_req_addr", 64'(o_req_addr), 64'd0);
    check("rst o_req_len", 64'(o_req_len), 64'd0);
    check("rst o_done", 64'(o_done), 64'd0);
    check("rst o_busy", 64'(o_busy), 64'd0);
    check("rst o_valid", 64'(o_valid), 64'd0);
    check("rst s_ready", 64'(s_ready), 64'd0);
    async_reset = 1'b0;

    // Master busy out of reset: the buffered chunk must wait for busy to fall.
    start_job(32'h1000, 32'd64);
    check("start o_busy", 64'(o_busy), 64'd1);
    for (int i = 0; i < 10; i++) tick();
    check("forced accepted", 64'(src_acc), 64'd8);
    check("forced o_req", 64'(o_req), 64'd0);
    check("forced req_count", 64'(req_addr_q.size()), 64'd0);
    force_busy = 1'b0;
    finish_job("basic");

    start_job(32'h1000, 32'd4096);
    finish_job("multi");

    // Zero length: done within three cycles, no request.
    start_job(32'h40, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("zero done_in_3", 64'(done_cnt), 64'd1);
    finish_job("zero");

    // Backpressure: master never ready, FIFO fills to depth while job still has beats left.
    rdy_allow = 1'b0;
    start_job(32'h8000, 32'd4800);
    n = 0;
    while (src_acc < 512 && n < 3000) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) tick();
    check("bp accepted", 64'(src_acc), 64'd512);
    check("bp s_ready", 64'(s_ready), 64'd0);
    check("bp fifo_count", 64'(dut.u_fifo.count), 64'd512);
    check("bp o_valid", 64'(o_valid), 64'd1);
    rdy_allow = 1'b1;
    finish_job("backpressure");

    // Address wraps modulo 2^32 between chunks.
    src_gap = 30; rdy_gap = 30;
    start_job(32'hFFFF_FC00, 32'd4096);
    finish_job("wrap");

    for (int j = 0; j < 4; j++) begin
      rbase   = $urandom;
      rbase   = rbase & 32'hFFFF_FFF8;
      rlen    = 32'($urandom_range(1, 700)) << DP;
      src_gap = $urandom_range(0, 60);
      rdy_gap = $urandom_range(0, 60);
      start_job(rbase, rlen);
      finish_job($sformatf("rand%0d", j));
    end
    src_gap = 0; rdy_gap = 0;

    // Reset mid-job: hold the master busy after its first chunk so the feeder sits in S_RUN.
    rdy_allow = 1'b0;
    start_job(32'h2000, 32'd2848);
    n = 0;
    while (src_acc < 356 && n < 3000) begin
      tick();
      n++;
    end
    check("mid accepted", 64'(src_acc), 64'd356);
    check("mid req_count", 64'(req_addr_q.size()), 64'd1);
    mst_hold  = 1'b1;
    rdy_allow = 1'b1;
    n = 0;
    while (mst_rem > 0 && n < 3000) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) tick();
    check("mid drained", 64'(got_q.size()), 64'd256);
    check("mid o_valid", 64'(o_valid), 64'd1);
    check("mid o_busy", 64'(o_busy), 64'd1);
    #2;
    async_reset = 1'b1;
    #1;
    check("arst o_valid", 64'(o_valid), 64'd0);
    check("arst o_busy", 64'(o_busy), 64'd0);
    check("arst o_req", 64'(o_req), 64'd0);
    check("arst o_req_addr", 64'(o_req_addr), 64'd0);
    check("arst o_req_len", 64'(o_req_len), 64'd0);
    check("arst s_ready", 64'(s_ready), 64'd0);
    src_q.delete();
    mst_hold = 1'b0; mst_act = 1'b0; mst_rem = 0;
    s_valid = 1'b0; i_ready = 1'b0; i_wr_busy = 1'b0;
    src_fire = 1'b0; snk_fire = 1'b0;
    tick();
    check("arst o_valid_edge", 64'(o_valid), 64'd0);
    check("arst o_done_edge", 64'(o_done), 64'd0);
    async_reset = 1'b0;
    tick();
    start_job(32'h1000, 32'd64);
    finish_job("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
